// File: rtl/muldiv_pkg.sv
// Shared op encoding, result type and op-class helpers for the multiply/divide unit.
// MULDIV_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate ops (7-10).
package muldiv_pkg;

    localparam int OP_W = 4;

    typedef logic [OP_W-1:0] op_t;
    typedef logic [63:0]     result_t;

    localparam op_t OP_NONE  = 4'd0;
    localparam op_t OP_MULT  = 4'd1;
    localparam op_t OP_MULTU = 4'd2;
    localparam op_t OP_DIV   = 4'd3;
    localparam op_t OP_DIVU  = 4'd4;
    localparam op_t OP_MTHI  = 4'd5;
    localparam op_t OP_MTLO  = 4'd6;
    localparam op_t OP_MADD  = 4'd7;
    localparam op_t OP_MADDU = 4'd8;
    localparam op_t OP_MSUB  = 4'd9;
    localparam op_t OP_MSUBU = 4'd10;

    // Ops that occupy the unit for MUL_CYCLES; accumulate ops only when built in.
    function automatic logic is_mul_op(input op_t op);
        logic r;
        r = 1'b0;
        case (op)
            OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_div_op(input op_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input op_t op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic        start;
    op_t         op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, rs_data, rt_data, input busy, hi, lo);
    modport slave  (input start, op, rs_data, rt_data, output busy, hi, lo);

endinterface

// File: rtl/muldiv_calc.sv
// Combinational product / quotient / remainder (and optional accumulate) datapath.
// The acc input and accumulate logic exist only when MULDIV_MADD_EN is defined.
module muldiv_calc
    import muldiv_pkg::*;
(
    input  op_t         op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
`ifdef MULDIV_MADD_EN
    input  result_t     acc,
`endif
    output result_t     result,
    output logic        div0
);

    logic        sgn_s;
    logic [63:0] prod_s;
    logic [31:0] dvd_s;
    logic [31:0] dvs_s;
    logic [31:0] quo_mag_s;
    logic [31:0] rem_mag_s;
    logic [31:0] quo_s;
    logic [31:0] rem_s;

    assign sgn_s = is_signed_op(op);
    assign div0  = (rt == 32'd0);

    // The low 64 bits of a 64x64 product of extended operands is the exact 32x32 product.
    assign prod_s = {{32{sgn_s & rs[31]}}, rs} * {{32{sgn_s & rt[31]}}, rt};

    // Signed division runs on magnitudes so -2^31 / -1 wraps cleanly to 0x80000000 rem 0.
    assign dvd_s     = (sgn_s && rs[31]) ? (32'd0 - rs) : rs;
    assign dvs_s     = div0 ? 32'd1 : ((sgn_s && rt[31]) ? (32'd0 - rt) : rt);
    assign quo_mag_s = dvd_s / dvs_s;
    assign rem_mag_s = dvd_s % dvs_s;
    assign quo_s     = (sgn_s && (rs[31] ^ rt[31])) ? (32'd0 - quo_mag_s) : quo_mag_s;
    assign rem_s     = (sgn_s && rs[31]) ? (32'd0 - rem_mag_s) : rem_mag_s;

    // Select the 64-bit result image {hi,lo} for the requested op.
    always_comb begin
        result = 64'd0;
        if (is_div_op(op)) begin
            result = {rem_s, quo_s};
        end else begin
            case (op)
`ifdef MULDIV_MADD_EN
                OP_MADD, OP_MADDU: result = acc + prod_s;
                OP_MSUB, OP_MSUBU: result = acc - prod_s;
`endif
                default: result = prod_s;
            endcase
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS multiply/divide unit holding the architectural HI/LO registers.
// Define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
)(
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave bus
);

    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_r;
    logic [0:0]       state_nxt_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    result_t          pend_r;
    result_t          pend_nxt_s;
    logic             pend_div0_r;
    logic             pend_div0_nxt_s;
    logic [31:0]      hi_r;
    logic [31:0]      hi_nxt_s;
    logic [31:0]      lo_r;
    logic [31:0]      lo_nxt_s;
    logic             busy_r;
    logic             busy_nxt_s;
    result_t          calc_s;
    logic             div0_s;

    muldiv_calc u_calc (
        .op     (bus.op),
        .rs     (bus.rs_data),
        .rt     (bus.rt_data),
`ifdef MULDIV_MADD_EN
        .acc    ({hi_r, lo_r}),
`endif
        .result (calc_s),
        .div0   (div0_s)
    );

    assign bus.busy = busy_r;
    assign bus.hi   = hi_r;
    assign bus.lo   = lo_r;

    // Next-state logic: accept ops only in IDLE, commit the pending result at the last RUN edge.
    always_comb begin
        state_nxt_s     = state_r;
        cnt_nxt_s       = cnt_r;
        pend_nxt_s      = pend_r;
        pend_div0_nxt_s = pend_div0_r;
        hi_nxt_s        = hi_r;
        lo_nxt_s        = lo_r;
        busy_nxt_s      = busy_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MTHI) begin
                        hi_nxt_s = bus.rs_data;
                    end else if (bus.op == OP_MTLO) begin
                        lo_nxt_s = bus.rs_data;
                    end else if (is_mul_op(bus.op)) begin
                        pend_nxt_s      = calc_s;
                        pend_div0_nxt_s = 1'b0;
                        cnt_nxt_s       = CNT_W'(MUL_CYCLES);
                        busy_nxt_s      = 1'b1;
                        state_nxt_s     = ST_RUN;
                    end else if (is_div_op(bus.op)) begin
                        pend_nxt_s      = calc_s;
                        pend_div0_nxt_s = div0_s;
                        cnt_nxt_s       = CNT_W'(DIV_CYCLES);
                        busy_nxt_s      = 1'b1;
                        state_nxt_s     = ST_RUN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r <= CNT_W'(1)) begin
                    if (!pend_div0_r) begin
                        hi_nxt_s = pend_r[63:32];
                        lo_nxt_s = pend_r[31:0];
                    end else begin
                        hi_nxt_s = hi_r;
                    end
                    cnt_nxt_s   = {CNT_W{1'b0}};
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                cnt_nxt_s   = {CNT_W{1'b0}};
                busy_nxt_s  = 1'b0;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers; reset aborts any operation.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= {CNT_W{1'b0}};
            pend_r      <= 64'd0;
            pend_div0_r <= 1'b0;
            hi_r        <= 32'd0;
            lo_r        <= 32'd0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cnt_r       <= cnt_nxt_s;
            pend_r      <= pend_nxt_s;
            pend_div0_r <= pend_div0_nxt_s;
            hi_r        <= hi_nxt_s;
            lo_r        <= lo_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers. Sits beside the EX stage of the 5-stage MIPS pipeline.
- Consumes the forwarded rs/rt operands and the decoded mul/div op from the ID/EX latch.
- Produces HI/LO for MFHI/MFLO, and a busy flag consumed by the stall controller.
- Stall controller must stall any mul/div-class instruction in ID while start or busy is high.

Parameters:
- MUL_CYCLES, 5, busy duration for MULT/MULTU (and MADD-family), min 1
- DIV_CYCLES, 10, busy duration for DIV/DIVU, min 1

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- start  in  1  op valid in EX this cycle (one-cycle pulse per instruction)
- op  in  4  operation code (muldiv_pkg encoding)
- rs_data  in  32  forwarded rs operand
- rt_data  in  32  forwarded rt operand
- busy  out  1  multi-cycle operation in flight
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (reset=0, async): hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts it; HI/LO stay 0.
- Op encoding: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, 9 MSUB, 10 MSUBU. All other codes behave as NONE.
- States: IDLE and RUN.
- IDLE, start=1, op MTHI/MTLO: hi (or lo) <= rs_data at that edge. busy stays 0.
- IDLE, start=1, op MULT/MULTU: 64-bit product computed from the edge-T operands into a pending register; counter <= MUL_CYCLES; go to RUN.
  - MULT is signed×signed. MULTU is unsigned.
- IDLE, start=1, op DIV/DIVU: pending quotient and remainder computed; counter <= DIV_CYCLES; go to RUN.
  - Signed division truncates toward zero. Remainder takes the sign of the dividend.
  - Pending LO = quotient, pending HI = remainder.
- RUN: busy=1; counter decrements each edge.
  - On the edge where counter==1: {hi,lo} <= pending, busy <= 0, return to IDLE.
- Timing for start at cycle T: busy high for cycles T+1..T+N; new HI/LO visible at T+N+1 together with busy=0.
- Divide by zero (rt_data==0): busy sequence unchanged, HI/LO left unmodified at commit.
- start=1 while busy=1: ignored entirely (protocol violation, since the stall controller prevents it). Includes MTHI/MTLO.
- start=0, or op NONE: no state change.
- Operands are sampled only at the start edge. Later changes on rs_data/rt_data have no effect.
- hi/lo are direct register outputs; no combinational path from inputs.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: ops 7-10 are legal and use MUL_CYCLES.
  - MADD/MADDU: {hi,lo} + product.
  - MSUB/MSUBU: {hi,lo} - product.
  - Signedness of the product follows MULT/MULTU. Accumulation is modulo 2^64.
  - {hi,lo} is sampled at the start edge.
- Undefined: ops 7-10 treated as NONE; no accumulate datapath is synthesized.

Decomposition:
- muldiv_pkg holds the op code constants (OP_NONE..OP_MSUBU), op width (4), and a 64-bit result typedef.
- One natural sub-module, muldiv_calc: combinational product / quotient / remainder / accumulate from op, rs, rt, {hi,lo}, plus a div-by-zero flag.
- muldiv_unit keeps the FSM, counter, pending register and HI/LO.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=5 -> busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU rs=7, rt=0 after MTHI 0x11/MTLO 0x22 -> busy 10 cycles; hi=0x11, lo=0x22 unchanged.
- MULT start, then reset pulled low at busy cycle 3 -> busy=0, hi=lo=0 immediately; a subsequent MTLO 0xABCD gives lo=0xABCD next cycle.
- With MULDIV_MADD_EN: hi=0, lo=0xFFFFFFFF, MADDU rs=1, rt=1 -> hi=0x00000001, lo=0x00000000 after 5 busy cycles.
- Without MULDIV_MADD_EN: the same MADDU (op 8) is a no-op, busy stays 0.
